// File: rtl/nn_ctrl_pkg.sv
// Shared definitions for the winner-take-all sequencing controller.
// Holds the FSM state encoding and the default iteration-limit parameters,
// so the controller and its bench agree on them.
package nn_ctrl_pkg;

  // Controller states; binary encoded.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    INIT = 3'd2,
    UPD  = 3'd3,
    CHK  = 3'd4,
    ITER = 3'd5,
    FIN  = 3'd6,
    DONE = 3'd7
  } state_t;

  // Default iteration limit and counter width (2^ITER_W must exceed MAX_ITER).
  localparam int MAX_ITER_DEF = 16;
  localparam int ITER_W_DEF   = 5;

endpackage

// File: rtl/nn_seq_ctrl_iter_counter.sv
// Saturating update counter for the sequencing controller.
// Synchronous clear has priority over increment; the count holds at its
// all-ones value instead of wrapping.
module iter_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] CNT_MAX = '1;

  // Count completed updates; clear at the start of a run, stop at full scale.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/nn_seq_ctrl.sv
// Sequencing controller for the 4-neuron winner-take-all datapath.
// Moore FSM: LOAD the inputs, INIT the processing unit from X, then loop
// UPD/CHK/ITER until the decoder reports convergence, latch the winner (FIN)
// and pulse done. All outputs are registered alongside the state.
// Optional feature: define NN_CTRL_TIMEOUT_EN to end a run with timeout=1
// once MAX_ITER updates have completed without convergence.
module nn_seq_ctrl
  import nn_ctrl_pkg::*;
#(
  parameter int MAX_ITER = MAX_ITER_DEF,
  parameter int ITER_W   = ITER_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              complete,
  output logic              sel,
  output logic              en0,
  output logic              en1,
  output logic              en2,
  output logic              en3,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [ITER_W-1:0] iter
);

  // The limit comparison needs headroom in the counter to be reachable.
  if (MAX_ITER >= (1 << ITER_W)) begin : g_bad_cfg
    $error("nn_seq_ctrl: ITER_W too narrow for MAX_ITER");
  end

  state_t state;
  logic   limit_hit;

`ifdef NN_CTRL_TIMEOUT_EN
  // Limit reached once the counter shows MAX_ITER completed updates.
  assign limit_hit = (iter == ITER_W'(MAX_ITER));
`else
  // No iteration limit: loop until the decoder converges.
  assign limit_hit = 1'b0;
`endif

  // Counter is cleared while in INIT and advanced once per UPD.
  iter_counter #(
    .W(ITER_W)
  ) u_iter (
    .clk  (clk),
    .rst  (rst),
    .clr  (state == INIT),
    .inc  (state == UPD),
    .count(iter)
  );

  // Next-state logic with outputs registered for the state being entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      sel     <= 1'b0;
      en0     <= 1'b0;
      en1     <= 1'b0;
      en2     <= 1'b0;
      en3     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      sel  <= 1'b0;
      en0  <= 1'b0;
      en1  <= 1'b0;
      en2  <= 1'b0;
      en3  <= 1'b0;
      done <= 1'b0;
      busy <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= LOAD;
            en0     <= 1'b1;
            timeout <= 1'b0;
          end else begin
            busy <= 1'b0;
          end
        end
        LOAD: begin
          state <= INIT;
          sel   <= 1'b1;
          en1   <= 1'b1;
        end
        INIT: begin
          state <= UPD;
          en2   <= 1'b1;
        end
        UPD: begin
          state <= CHK;
        end
        CHK: begin
          // Convergence takes precedence over the iteration limit.
          if (complete) begin
            state <= FIN;
            en3   <= 1'b1;
          end else if (limit_hit) begin
            state   <= DONE;
            done    <= 1'b1;
            timeout <= 1'b1;
          end else begin
            state <= ITER;
            en1   <= 1'b1;
          end
        end
        ITER: begin
          state <= UPD;
          en2   <= 1'b1;
        end
        FIN: begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/nn_seq_ctrl.md
# nn_seq_ctrl

Sequencing controller for the 4-neuron competitive (winner-take-all) network datapath. It accepts a start request, loads the four input activations, and iterates the processing-unit/activation-register loop until the datapath's decoder reports `complete`. It then latches the winning input into the result register and signals done. The block sits directly above the datapath and drives its `sel`, `en0`..`en3` controls.

## Interface
- `MAX_ITER`, 16, maximum update iterations before timeout; only meaningful with `NN_CTRL_TIMEOUT_EN`
- `ITER_W`, 5, width of the iteration counter; must satisfy 2^ITER_W > MAX_ITER
- `clk`  input  1  single clock, rising edge
- `rst`  input  1  reset, asynchronous, active-low
- `start`  input  1  run request, sampled only in IDLE
- `complete`  input  1  datapath decoder convergence flag, sampled only in CHK
- `sel`  output  1  activation mux select; 1 = initial X values, 0 = fed-back activations
- `en0`  output  1  X input register load
- `en1`  output  1  processing-unit register enable
- `en2`  output  1  activation register load
- `en3`  output  1  final result register load
- `busy`  output  1  high in every state except IDLE
- `done`  output  1  one-cycle pulse at end of run
- `timeout`  output  1  valid with `done`; run ended without convergence
- `iter`  output  ITER_W  number of completed updates in the current or last run

## Operation
- Moore FSM, one-hot or binary encoding. Outputs decode from the state register only.
- IDLE: all enables 0, `sel`=0. `start`=1 -> LOAD.
- LOAD: `en0`=1 -> INIT.
- INIT: `sel`=1, `en1`=1; `iter` cleared -> UPD.
- UPD: `en2`=1; `iter` += 1 -> CHK.
- CHK: all enables 0. `complete`=1 -> FIN; else if limit reached (see Configuration) -> DONE with `timeout` set; else -> ITER.
- ITER: `sel`=0, `en1`=1 -> UPD.
- FIN: `en3`=1 -> DONE.
- DONE: `done`=1 for one cycle -> IDLE. `timeout` holds its value until the next LOAD.
- `iter` saturates at 2^ITER_W-1 and never wraps.
- `start` is ignored while `busy`. If `start` is still high when IDLE is re-entered, a new run begins on the next edge.
- `complete` is ignored outside CHK. Its value in CHK reflects the activation register written in the preceding UPD.

## Timing
- Reset: all outputs 0, `iter`=0, state IDLE. Reset takes effect immediately, including mid-run; enables drop in the same cycle.
- Edge E0 samples `start`. Then LOAD runs at E0+1, INIT at +2, UPD at +3, CHK at +4.
- Convergence after N updates: FIN at +3N+2, `done` at +3N+3.
- Each extra iteration adds 3 cycles (ITER, UPD, CHK).
- Timeout after MAX_ITER updates: `done`+`timeout` at +3·MAX_ITER+2; `en3` is never asserted, so the result register keeps its previous value.
- `complete` and the limit true in the same CHK: `complete` wins, giving FIN with `timeout`=0.

## Configuration
- `NN_CTRL_TIMEOUT_EN` defined: in CHK, `iter`==MAX_ITER with `complete`=0 -> DONE with `timeout`=1.
- Undefined: no limit; the FSM loops ITER/UPD/CHK until `complete`. `timeout` is tied to 0. `MAX_ITER` is unused.

## Structure
- Shared package `nn_ctrl_pkg` holds the state encoding constants (IDLE, LOAD, INIT, UPD, CHK, ITER, FIN, DONE) and the default MAX_ITER/ITER_W values, for reuse by the top-level and the bench.
- One sub-module, `iter_counter`: clear, increment enable, saturating ITER_W-bit count, async active-low reset.

## Test plan
- Reset: hold `rst`=0 with `start`=1 -> all outputs 0 and `iter`=0; release -> LOAD one cycle later.
- Single update: `start` pulse, stub `complete`=1 -> `en0` at +1, `sel`&`en1` at +2, `en2` at +3, `en3` at +5, `done` at +6, `iter`=1, `timeout`=0.
- Three updates: `complete`=1 only in the third CHK -> `en2` pulses 3 times, `sel`=0 in both ITER cycles, `done` at +12, `iter`=3.
- Timeout (macro on, MAX_ITER=4): `complete` held 0 -> `done`&`timeout` at +14, no `en3`, `iter`=4. With the macro off, still running at +100.
- `start` held high across the run -> second LOAD immediately after the IDLE following DONE. A `start` pulse mid-run has no effect.
- `rst` low during UPD -> `en2` falls without a clock edge, `busy`=0, `iter`=0; a new `start` gives a normal run.
